// File: rtl/password_stream_gen_pkg.sv
// Shared constants and state type for the candidate-password stream source.
// Channel codes and the mgmt payload match what test_core's sink expects.
package password_stream_gen_pkg;

  localparam logic        CH_DATA   = 1'b0;
  localparam logic        CH_MGMT   = 1'b1;
  localparam logic [15:0] MGMT_DATA = 16'h0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    WORD   = 3'd2,
    COMMIT = 3'd3,
    FIN    = 3'd4
  } gen_state_t;

  // True for the states that present a beat on the stream.
  function automatic logic is_beat_state(input gen_state_t s);
    return (s == INIT) || (s == WORD) || (s == COMMIT);
  endfunction

endpackage

// File: rtl/password_stream_gen_if.sv
// Avalon-ST link (readyLatency 0) between the password generator and test_core.
interface password_stream_gen_if #(
  parameter int DATA_W = 16
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_channel;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_channel,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_channel,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/password_stream_gen.sv
// Candidate-password source: one mgmt init beat, then per candidate WORDS data
// beats (MS word first) and a mgmt commit beat. All outputs are registered.
module password_stream_gen
  import password_stream_gen_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WORDS  = 3,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [DATA_W*WORDS-1:0]   base_pw,
  input  logic [CNT_W-1:0]          num_pw,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          sent_count,
  password_stream_gen_if.master     st
);

  localparam int PW_W  = DATA_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  gen_state_t        state_q, state_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [PW_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              abort_q, abort_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_channel_q, out_channel_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer_s;
  logic              accept_s;
  logic              abort_seen_s;

  // Word k of a candidate, counted from the most significant end.
  function automatic logic [DATA_W-1:0] word_of(input logic [PW_W-1:0] c,
                                                input logic [IDX_W-1:0] k);
    return c[PW_W-1-int'(k)*DATA_W -: DATA_W];
  endfunction

  assign xfer_s       = out_valid_q && st.out_ready;
  // FIN already shows busy low, so a start there is honoured as well.
  assign accept_s     = start && !busy_q && ((state_q == IDLE) || (state_q == FIN));
  assign abort_seen_s = abort_q || (abort && busy_q);

  // Next-state: sequencing of beats, candidate/counter bookkeeping, abort latch.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    cand_d      = cand_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    pend_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = (remaining_q == '0) ? FIN : INIT;
        end else begin
          state_d = IDLE;
        end
      end
      INIT: begin
        if (xfer_s) begin
          state_d = WORD;
          widx_d  = '0;
        end else begin
          state_d = INIT;
        end
      end
      WORD: begin
        if (xfer_s && (widx_q == LAST_IDX)) begin
          state_d = COMMIT;
        end else if (xfer_s) begin
          widx_d = widx_q + IDX_W'(1);
        end else begin
          state_d = WORD;
        end
      end
      COMMIT: begin
        if (xfer_s) begin
          sent_d = sent_q + CNT_W'(1);
          if ((remaining_q == CNT_W'(1)) || abort_seen_s) begin
            state_d = FIN;
          end else begin
            state_d     = WORD;
            widx_d      = '0;
            cand_d      = cand_q + PW_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
          end
        end else begin
          state_d = COMMIT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept_s) begin
      pend_d      = 1'b1;
      cand_d      = base_pw;
      remaining_d = num_pw;
      sent_d      = '0;
    end else begin
      pend_d = 1'b0;
    end
    // The latch only lives while beats are still to come; it is also dropped on a new start.
    abort_d = abort_seen_s && is_beat_state(state_d);
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    out_valid_d   = is_beat_state(state_d);
    out_channel_d = 1'b0;
    out_data_d    = '0;
    case (state_d)
      INIT, COMMIT: begin
        out_channel_d = CH_MGMT;
        out_data_d    = DATA_W'(MGMT_DATA);
      end
      WORD: begin
        out_channel_d = CH_DATA;
        out_data_d    = word_of(cand_d, widx_d);
      end
      default: begin
        out_channel_d = 1'b0;
        out_data_d    = '0;
      end
    endcase
    busy_d = is_beat_state(state_d) || pend_d;
    done_d = (state_d == FIN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      widx_q        <= '0;
      cand_q        <= '0;
      remaining_q   <= '0;
      sent_q        <= '0;
      abort_q       <= 1'b0;
      pend_q        <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      cand_q        <= cand_d;
      remaining_q   <= remaining_d;
      sent_q        <= sent_d;
      abort_q       <= abort_d;
      pend_q        <= pend_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign st.out_data    = out_data_q;
  assign st.out_channel = out_channel_q;
  assign st.out_valid   = out_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sent_count     = sent_q;

endmodule

// File: tb/tb_password_stream_gen.sv
// Self-checking bench: a beat-list model built from base/num is compared
// against every stream transfer, plus directed checks of timing and counters.
module tb_password_stream_gen;

  localparam int DATA_W = 16;
  localparam int WORDS  = 3;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [47:0]       base_pw;
  logic [31:0]       num_pw;
  logic              busy;
  logic              done;
  logic [31:0]       sent_count;

  password_stream_gen_if #(.DATA_W(DATA_W)) st ();

  password_stream_gen #(.DATA_W(DATA_W), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .base_pw    (base_pw),
    .num_pw     (num_pw),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count),
    .st         (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ch;
    logic [15:0] data;
    bit          commit;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_ch;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beat list for a run, derived directly from the stream format.
  task automatic model_load(input logic [47:0] b, input logic [31:0] n);
    logic [47:0] c;
    beat_t       x;
    c = b;
    if (n == 32'd0) return;
    x.ch = 1'b1; x.data = 16'h0000; x.commit = 1'b0;
    exp_q.push_back(x);
    for (int i = 0; i < int'(n); i++) begin
      for (int w = 0; w < WORDS; w++) begin
        x.ch = 1'b0;
        x.data = 16'(c >> (16 * (WORDS - 1 - w)));
        x.commit = 1'b0;
        exp_q.push_back(x);
      end
      x.ch = 1'b1; x.data = 16'h0000; x.commit = 1'b1;
      exp_q.push_back(x);
      c = c + 48'd1;
    end
  endtask

  // Abort: the candidate in progress finishes with its commit, nothing after.
  task automatic model_abort();
    int k;
    k = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].commit && k < 0) k = i;
    end
    while (k >= 0 && exp_q.size() > k + 1) void'(exp_q.pop_back());
  endtask

  always @(posedge clk) begin
    #1;
    st.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every transfer against the model, stall stability, done pulses.
  always @(negedge clk) begin
    beat_t b;
    if (reset_n === 1'b1) begin
      if (prev_stall) begin
        check("stall_valid", st.out_valid, 1'b1);
        check("stall_data", st.out_data, prev_data);
        check("stall_ch", st.out_channel, prev_ch);
      end
      if (st.out_valid && st.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got ch=%0h data=%0h expected no beat (t=%0t)",
                   st.out_channel, st.out_data, $time);
        end else begin
          b = exp_q.pop_front();
          check("beat_ch", st.out_channel, b.ch);
          check("beat_data", st.out_data, b.data);
        end
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 1'b0);
      end
      prev_stall = st.out_valid && !st.out_ready;
      prev_data  = st.out_data;
      prev_ch    = st.out_channel;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_start(input logic [47:0] b, input logic [31:0] n);
    @(posedge clk); #1;
    base_pw = b; num_pw = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
    end
    check("done_seen", (done_cnt > d0), 1'b1);
  endtask

  task automatic wait_xfers(input int x0, input int n);
    for (int i = 0; i < 500 && (xfer_cnt - x0) < n; i++) begin
      @(posedge clk); #1;
    end
    check("xfer_reached", ((xfer_cnt - x0) >= n), 1'b1);
  endtask

  task automatic scen1();
    int d0;
    model_load(48'h0004a53cf15b, 32'd1);
    check("s1_model_len", exp_q.size(), 5);
    check("s1_model_w0", exp_q[1].data, 16'h0004);
    check("s1_model_w1", exp_q[2].data, 16'ha53c);
    check("s1_model_w2", exp_q[3].data, 16'hf15b);
    d0 = done_cnt;
    do_start(48'h0004a53cf15b, 32'd1);
    check("s1_busy_after_start", busy, 1'b1);
    check("s1_valid_pending", st.out_valid, 1'b0);
    check("s1_sent_cleared", sent_count, 32'd0);
    @(posedge clk); #1;
    check("s1_first_valid", st.out_valid, 1'b1);
    check("s1_first_ch", st.out_channel, 1'b1);
    wait_done(d0);
    check("s1_sent", sent_count, 32'd1);
    check("s1_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("s1_sent_hold", sent_count, 32'd1);
    check("s1_done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int x0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_pw = '0; num_pw = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", st.out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sent", sent_count, 32'd0);
    check("rst_data", st.out_data, 16'h0000);
    check("rst_ch", st.out_channel, 1'b0);
    reset_n = 1'b1;

    scen1();

    rand_ready = 1'b1;
    model_load(48'habcdef012300, 32'd3);
    check("s2_model_len", exp_q.size(), 13);
    check("s2_model_c1", exp_q[7].data, 16'h2301);
    check("s2_model_c2", exp_q[11].data, 16'h2302);
    d0 = done_cnt;
    do_start(48'habcdef012300, 32'd3);
    wait_done(d0);
    check("s2_sent", sent_count, 32'd3);
    check("s2_queue_empty", exp_q.size(), 0);
    check("s2_done_count", done_cnt - d0, 1);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);

    model_load(48'hffffffffffff, 32'd2);
    check("s3_model_len", exp_q.size(), 9);
    check("s3_model_w0", exp_q[5].data, 16'h0000);
    check("s3_model_w2", exp_q[7].data, 16'h0000);
    d0 = done_cnt; x0 = xfer_cnt;
    do_start(48'hffffffffffff, 32'd2);
    wait_done(d0);
    check("s3_sent", sent_count, 32'd2);
    check("s3_beats", xfer_cnt - x0, 9);
    check("s3_queue_empty", exp_q.size(), 0);

    d0 = done_cnt; x0 = xfer_cnt;
    do_start(48'h123456789abc, 32'd0);
    check("s4_busy", busy, 1'b1);
    check("s4_done_early", done, 1'b0);
    @(posedge clk); #1;
    check("s4_done", done, 1'b1);
    check("s4_busy_low", busy, 1'b0);
    check("s4_valid", st.out_valid, 1'b0);
    @(posedge clk); #1;
    check("s4_done_pulse", done, 1'b0);
    check("s4_sent", sent_count, 32'd0);
    check("s4_no_beats", xfer_cnt - x0, 0);

    model_load(48'h000012340000, 32'd10);
    d0 = done_cnt; x0 = xfer_cnt;
    do_start(48'h000012340000, 32'd10);
    wait_xfers(x0, 6);
    abort = 1'b1;
    model_abort();
    @(posedge clk); #1;
    abort = 1'b0;
    base_pw = 48'h555555555555; num_pw = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0);
    check("s5_sent", sent_count, 32'd2);
    check("s5_beats", xfer_cnt - x0, 9);
    check("s5_queue_empty", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    check("s5_no_restart", busy, 1'b0);
    check("s5_done_count", done_cnt - d0, 1);

    model_load(48'h0004a53cf15b, 32'd1);
    d0 = done_cnt; x0 = xfer_cnt;
    do_start(48'h0004a53cf15b, 32'd1);
    wait_xfers(x0, 3);
    check("s6_at_w2", st.out_data, 16'hf15b);
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("s6_valid", st.out_valid, 1'b0);
    check("s6_busy", busy, 1'b0);
    check("s6_done", done, 1'b0);
    check("s6_sent", sent_count, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s6_no_done", done_cnt - d0, 0);
    scen1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
